// File: rtl/therm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : therm_pkg
// Description : Shared constants and helpers for the thermometer-code
//               cleanup path (encoder -> bubble filter -> decoder).
//               K_DEF     - default binary width of the decoded code
//               W_DEF     - default thermometer word width (2**K_DEF-1)
//               CNT_W_DEF - default error counter width
//               is_thermometer() - legality check for a thermometer word
// Revision    : 1.0 - initial release
// ============================================================================
package therm_pkg;

    localparam int K_DEF     = 5;
    localparam int W_DEF     = 2**K_DEF - 1;
    localparam int CNT_W_DEF = 8;

    // Widest thermometer word the helper below can judge. Callers
    // zero-extend narrower words into this width.
    localparam int MAX_W     = 64;

    // A legal thermometer word is a contiguous run of ones starting at bit 0
    // (including all-zero and all-ones). Such a word plus one is a single
    // power of two, so it shares no set bit with the original. The input is
    // zero-extended, so the carry out of an all-ones W-bit word lands in a
    // bit that is zero in the word itself and all-ones stays legal.
    function automatic logic is_thermometer(input logic [MAX_W-1:0] word);
        logic [MAX_W-1:0] w_next;
        w_next = word + MAX_W'(1);
        return ((word & w_next) == '0);
    endfunction

endpackage : therm_pkg
`default_nettype wire

// File: rtl/thermometer_bubble_vote.sv
`default_nettype none
// ============================================================================
// Module      : thermometer_bubble_vote
// Description : Combinational single-bit bubble corrector. Every output bit
//               is the 3-input majority of itself and its two neighbours.
//               Below bit 0 the code is taken as 1 and above bit W-1 as 0,
//               which is what a thermometer word looks like beyond its ends.
// Ports       : raw       [W-1:0] in  - word to correct
//               corrected [W-1:0] out - majority-voted word
//               bubble            out - corrected differs from raw
// Revision    : 1.0 - initial release
// ============================================================================
module thermometer_bubble_vote #(
    parameter int W = 31
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] corrected,
    output logic         bubble
);

    // raw padded with the implied boundary bits: w_ext[0] is level -1,
    // w_ext[W+1] is level W.
    logic [W+1:0] w_ext;

    assign w_ext = {1'b0, raw, 1'b1};

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic w_lo;
        logic w_mid;
        logic w_hi;

        assign w_lo  = w_ext[i];
        assign w_mid = w_ext[i+1];
        assign w_hi  = w_ext[i+2];

        assign corrected[i] = (w_lo & w_mid) | (w_mid & w_hi) | (w_lo & w_hi);
    end

    assign bubble = (corrected != raw);

endmodule : thermometer_bubble_vote
`default_nettype wire

// File: rtl/thermometer_bubble_filter.sv
`default_nettype none
// ============================================================================
// Module      : thermometer_bubble_filter
// Description : Two-stage valid/ready pipeline that removes single-bit
//               bubbles from a thermometer word, flags words that are still
//               illegal after correction and keeps a saturating count of
//               delivered words that carried either flag.
//               S1 holds the raw word; S2 holds the corrected word and its
//               flags and drives every out_* port directly.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid/in_ready/in_therm  - upstream handshake and word
//               out_valid/out_ready         - downstream handshake
//               out_therm                   - corrected word
//               out_bubble                  - correction changed a bit
//               out_invalid                 - corrected word still illegal
//               err_clr                     - synchronous counter clear
//               err_count                   - saturating error counter
// Revision    : 1.0 - initial release
// ============================================================================
module thermometer_bubble_filter
    import therm_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int W     = 2**K - 1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_therm,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_therm,
    output logic             out_bubble,
    output logic             out_invalid,

    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_therm;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_therm;
    logic             r_s2_bubble;
    logic             r_s2_invalid;
    logic [CNT_W-1:0] r_err_count;

    // ------------------------------------------------------------------
    // Correction on S1 contents
    // ------------------------------------------------------------------
    logic [W-1:0]     w_corr;
    logic             w_bubble;
    logic             w_invalid;

    thermometer_bubble_vote #(
        .W (W)
    ) u_vote (
        .raw       (r_s1_therm),
        .corrected (w_corr),
        .bubble    (w_bubble)
    );

    assign w_invalid = !is_thermometer(MAX_W'(w_corr));

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // S2 takes a new word when S1 has one and S2 is either empty or being
    // emptied this cycle. in_ready follows out_ready combinationally; there
    // is no skid buffer, so a full pipe stalls upstream in the same cycle.
    logic w_s2_load;
    logic w_accept;
    logic w_deliver;
    logic w_err_event;

    assign w_s2_load   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready    = !r_s1_valid || w_s2_load;
    assign w_accept    = in_valid && in_ready;
    assign w_deliver   = r_s2_valid && out_ready;
    assign w_err_event = w_deliver && (r_s2_bubble || r_s2_invalid);

    // ------------------------------------------------------------------
    // Stage 1: raw word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_therm <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_therm <= in_therm;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: corrected word and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_therm   <= '0;
            r_s2_bubble  <= 1'b0;
            r_s2_invalid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid   <= 1'b1;
            r_s2_therm   <= w_corr;
            r_s2_bubble  <= w_bubble;
            r_s2_invalid <= w_invalid;
        end else if (out_ready) begin
            r_s2_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter; clear has priority over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_err_event && (r_err_count != C_CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_therm   = r_s2_therm;
    assign out_bubble  = r_s2_bubble;
    assign out_invalid = r_s2_invalid;
    assign err_count   = r_err_count;

endmodule : thermometer_bubble_filter
`default_nettype wire

// File: tb/tb_thermometer_bubble_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_thermometer_bubble_filter
// Description : Self-checking bench for thermometer_bubble_filter. A second
//               instance with a 2-bit counter shares all inputs so counter
//               saturation can be observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_thermometer_bubble_filter;

    localparam int W = 31;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic         bub;
        logic         inv;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_therm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_therm;
    logic         out_bubble;
    logic         out_invalid;
    logic         err_clr;
    logic [7:0]   err_count;

    logic         d2_in_ready;
    logic         d2_out_valid;
    logic [W-1:0] d2_out_therm;
    logic         d2_out_bubble;
    logic         d2_out_invalid;
    logic [1:0]   d2_err_count;

    int checks   = 0;
    int failures = 0;

    thermometer_bubble_filter #(.K(5), .W(W), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_therm   (in_therm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_therm  (out_therm),
        .out_bubble (out_bubble),
        .out_invalid(out_invalid),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    thermometer_bubble_filter #(.K(5), .W(W), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (d2_in_ready),
        .in_therm   (in_therm),
        .out_valid  (d2_out_valid),
        .out_ready  (out_ready),
        .out_therm  (d2_out_therm),
        .out_bubble (d2_out_bubble),
        .out_invalid(d2_out_invalid),
        .err_clr    (err_clr),
        .err_count  (d2_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: leaves the bench at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference thermometer encoder and decoder.
    function automatic logic [W-1:0] enc(input int a);
        logic [31:0] t;
        t = (32'd1 << a) - 32'd1;
        return t[W-1:0];
    endfunction

    function automatic int popcnt(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    // Push one word in with out_ready high and wait for it at the output.
    task automatic send_one(input logic [W-1:0] w, output logic [W-1:0] ot,
                            output logic ob, output logic oi, output int lat);
        in_valid = 1'b1;
        in_therm = w;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        ot = out_therm;
        ob = out_bubble;
        oi = out_invalid;
    endtask

    initial begin
        vec_t         tbl[9];
        logic [W-1:0] words[4];
        logic [W-1:0] ot;
        logic         ob;
        logic         oi;
        int           lat;
        int           exp_cnt;
        int           idx;
        int           got;
        int           q[$];
        int           cyc;

        tbl[0] = '{din: 31'h0000_00FF, dout: 31'h0000_00FF, bub: 1'b0, inv: 1'b0};
        tbl[1] = '{din: 31'h0000_00FB, dout: 31'h0000_00FF, bub: 1'b1, inv: 1'b0};
        tbl[2] = '{din: 31'h0000_0004, dout: 31'h0000_0000, bub: 1'b1, inv: 1'b0};
        tbl[3] = '{din: 31'h0000_0005, dout: 31'h0000_0003, bub: 1'b1, inv: 1'b0};
        tbl[4] = '{din: 31'h0000_0033, dout: 31'h0000_0033, bub: 1'b0, inv: 1'b1};
        tbl[5] = '{din: 31'h0000_0000, dout: 31'h0000_0000, bub: 1'b0, inv: 1'b0};
        tbl[6] = '{din: 31'h7FFF_FFFF, dout: 31'h7FFF_FFFF, bub: 1'b0, inv: 1'b0};
        tbl[7] = '{din: 31'h4000_0000, dout: 31'h0000_0000, bub: 1'b1, inv: 1'b0};
        tbl[8] = '{din: 31'h3FFF_FFFE, dout: 31'h3FFF_FFFF, bub: 1'b1, inv: 1'b0};

        words[0] = 31'h1;
        words[1] = 31'h3;
        words[2] = 31'h7;
        words[3] = 31'hF;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_therm  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        step();
        step();

        // Reset state
        check("rst_out_valid",  64'(out_valid),   64'd0);
        check("rst_in_ready",   64'(in_ready),    64'd1);
        check("rst_err_count",  64'(err_count),   64'd0);
        check("rst_out_therm",  64'(out_therm),   64'd0);
        check("rst_out_flags",  64'({out_bubble, out_invalid}), 64'd0);
        rst_n = 1'b1;
        step();

        // Table-driven single words, out_ready held high
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            send_one(tbl[i].din, ot, ob, oi, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
            check($sformatf("vec%0d_therm", i),   64'(ot),  64'(tbl[i].dout));
            check($sformatf("vec%0d_bubble", i),  64'(ob),  64'(tbl[i].bub));
            check($sformatf("vec%0d_invalid", i), 64'(oi),  64'(tbl[i].inv));
            step();
            if ((tbl[i].bub || tbl[i].inv) && exp_cnt < 255) exp_cnt++;
            check($sformatf("vec%0d_err_count", i), 64'(err_count), 64'(exp_cnt));
            check($sformatf("vec%0d_drained", i),   64'(out_valid), 64'd0);
        end

        // Backpressure: two words fill the pipe, then in_ready drops
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            in_therm = (idx < 4) ? words[idx] : '0;
            #1;
            if (in_valid && in_ready) idx++;
            step();
        end
        #1;
        check("bp_accepts",     64'(idx),       64'd2);
        check("bp_in_ready",    64'(in_ready),  64'd0);
        check("bp_out_valid",   64'(out_valid), 64'd1);
        check("bp_stall_therm", 64'(out_therm), 64'h1);
        step();
        step();
        check("bp_stall_hold",  64'(out_therm), 64'h1);
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 30) begin
            in_valid = (idx < 4);
            in_therm = (idx < 4) ? words[idx] : '0;
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", got), 64'(out_therm), 64'(words[got]));
                got++;
            end
            if (in_valid && in_ready) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_delivered", 64'(got), 64'd4);
        step();
        check("bp_no_dup", 64'(out_valid), 64'd0);

        // Counter limits: clear, stall a bubbled word, then saturate
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_count",  64'(err_count),    64'd0);
        check("clr_count2", 64'(d2_err_count), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_therm  = 31'h0000_00FB;
        step();
        in_valid  = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("stall_valid",  64'(out_valid), 64'd1);
        check("stall_count",  64'(err_count), 64'd0);
        out_ready = 1'b1;
        step();
        check("stall_release_count", 64'(err_count), 64'd1);
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            in_valid = 1'b1;
            in_therm = 31'h0000_00FB;
            #1;
            if (in_ready) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("sat_count8", 64'(err_count),    64'd5);
        check("sat_count2", 64'(d2_err_count), 64'd3);
        send_one(31'h0000_00FB, ot, ob, oi, lat);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_wins8", 64'(err_count),    64'd0);
        check("clr_wins2", 64'(d2_err_count), 64'd0);

        // End to end: encoder -> filter -> decoder with random out_ready
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 32 && cyc < 2000) begin
            in_valid  = (idx < 32);
            in_therm  = (idx < 32) ? enc(idx) : '0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("e2e_spurious", 64'd1, 64'd0);
                end else begin
                    check($sformatf("e2e_a%0d", q[0]), 64'(popcnt(out_therm)), 64'(q[0]));
                    void'(q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(idx);
                idx++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("e2e_count", 64'(got), 64'd32);
        check("e2e_no_err", 64'(err_count), 64'd0);

        // Reset asserted mid-stream
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_therm = 31'h0000_00FB;
            step();
        end
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        check("mid_pre_count", 64'(err_count), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  64'(out_valid),    64'd0);
        check("mid_rst_count",  64'(err_count),    64'd0);
        check("mid_rst_count2", 64'(d2_err_count), 64'd0);
        check("mid_rst_ready",  64'(in_ready),     64'd1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("mid_no_replay", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_thermometer_bubble_filter
`default_nettype wire
